// File: rtl/load_store_unit_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The unit itself uses the slave modport; the core/memory environment uses master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_write_enable;
  logic        store_enable;
  logic [31:0] mem_read_data;

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_write_data, mem_write_enable, store_enable
  );

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_address, mem_write_data, mem_write_enable, store_enable
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator: checks the request, drives the byte-lane
// memory port for WAIT_CYCLES+1 cycles, and returns the extended load data or a fault code.
module load_store_unit #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clk,
  input  logic               rst,
  load_store_unit_if.slave   bus
);
  localparam int       NUM_LANES = 4;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {
    F_OK = 2'b00, F_MISALIGN = 2'b01, F_RANGE = 2'b10, F_FUNCT3 = 2'b11
  } fault_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  fault_q, fault_d;

  logic [1:0]  req_off;
  logic [1:0]  req_fault;
  logic        illegal, misaligned, out_of_range;
  logic [NUM_LANES-1:0]      lane_we;
  logic [NUM_LANES-1:0][7:0] lane_wd;
  logic [31:0] load_ext;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        last_access;

  assign req_off = bus.req_addr[1:0];

  always_comb begin
    illegal      = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111) || (bus.req_is_store && bus.req_funct3[2]);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && req_off[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
    out_of_range = (bus.req_addr >> ADDR_BITS) != 32'd0;
    if (illegal)           req_fault = F_FUNCT3;
    else if (misaligned)   req_fault = F_MISALIGN;
    else if (out_of_range) req_fault = F_RANGE;
    else                   req_fault = F_OK;
  end

  // Per byte lane: enable and the slice of right-aligned store data replicated into it.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam logic [1:0] LN = 2'(l);
    always_comb begin
      unique case (bus.req_funct3[1:0])
        2'b00: begin
          lane_we[l] = (req_off == LN);
          lane_wd[l] = bus.req_wdata[7:0];
        end
        2'b01: begin
          lane_we[l] = (req_off[1] == LN[1]);
          lane_wd[l] = bus.req_wdata[8*(l%2) +: 8];
        end
        default: begin
          lane_we[l] = 1'b1;
          lane_wd[l] = bus.req_wdata[8*l +: 8];
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = bus.mem_read_data[{off_q, 3'b000} +: 8];
    ld_half = bus.mem_read_data[{off_q[1], 4'b0000} +: 16];
    unique case (funct3_q)
      3'b000:  load_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_ext = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_ext = bus.mem_read_data;
      3'b100:  load_ext = {24'd0, ld_byte};
      3'b101:  load_ext = {16'd0, ld_half};
      default: load_ext = 32'd0;
    endcase
  end

  assign last_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    fault_d    = fault_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          is_store_d = bus.req_is_store;
          funct3_d   = bus.req_funct3;
          off_d      = req_off;
          rdata_d    = 32'd0;
          fault_d    = req_fault;
          if (req_fault != F_OK) begin
            state_d = RESP;
          end else begin
            state_d = ACCESS;
            cnt_d   = 4'd0;
            addr_d  = {bus.req_addr[31:2], 2'b00};
            if (bus.req_is_store) begin
              wdata_d = lane_wd;
              we_d    = lane_we;
            end else begin
              we_d    = 4'd0;
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          state_d = RESP;
          we_d    = 4'd0;
          if (!is_store_q) rdata_d = load_ext;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_store_q <= 1'b0;
      funct3_q   <= 3'd0;
      off_q      <= 2'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      we_q       <= 4'd0;
      rdata_q    <= 32'd0;
      fault_q    <= F_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.resp_valid       = (state_q == RESP);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_fault       = fault_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.mem_write_enable = we_q;
  // Strobe is combinational so a reset arriving in the due cycle can still kill it.
  assign bus.store_enable     = last_access && is_store_q && !rst;
endmodule
